// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle: one request channel (op + operands) and one
// response channel (result + zero flag), each with its own valid/ready.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;

  // Requester side.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a single combinational ALU.
// A granted request is registered onto the ALU inputs, the ALU output is
// captured one cycle later and held on the owner's response port until
// that requester accepts it. One operation is in flight at a time.
module alu_share_arbiter #(
  parameter int DATA_W   = 32,
  parameter int OP_W     = 4,
  parameter bit RST_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave port0,
  alu_share_arbiter_if.slave port1,
  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              last;    // requester granted most recently
  logic              owner;   // requester whose operation is in flight
  logic              grant;
  logic [1:0]        valid;
  logic [1:0]        rsp_vld;
  logic [DATA_W-1:0] res;
  logic              res_zero;

  assign valid = {port1.req_valid, port0.req_valid};

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (&valid)        grant = ~last;
    else if (valid[1]) grant = 1'b1;
  end

  assign port0.req_ready = (state == IDLE) && valid[0] && !grant;
  assign port1.req_ready = (state == IDLE) && valid[1] &&  grant;

  // Control FSM plus the ALU-input and result-capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= RST_LAST;
      owner       <= 1'b0;
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res         <= '0;
      res_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|valid) begin
            alu_control <= grant ? port1.req_op : port0.req_op;
            alu_a       <= grant ? port1.req_a  : port0.req_a;
            alu_b       <= grant ? port1.req_b  : port0.req_b;
            owner       <= grant;
            last        <= grant;
            state       <= EXEC;
          end
        end
        EXEC: begin
          res      <= alu_result;
          res_zero <= alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (owner ? port1.rsp_ready : port0.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the owner sees the held result; the other port reads all zeros.
  assign rsp_vld[0] = (state == RESP) && !owner;
  assign rsp_vld[1] = (state == RESP) &&  owner;

  assign port0.rsp_valid  = rsp_vld[0];
  assign port0.rsp_result = rsp_vld[0] ? res : '0;
  assign port0.rsp_zero   = rsp_vld[0] & res_zero;
  assign port1.rsp_valid  = rsp_vld[1];
  assign port1.rsp_result = rsp_vld[1] ? res : '0;
  assign port1.rsp_zero   = rsp_vld[1] & res_zero;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized
// operations, checked against an arbitration/latency model and an ALU
// reference function.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [OW-1:0] alu_control;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_zero, busy;

  int   checks = 0;
  int   errors = 0;
  logic last_m;   // model: requester served most recently

  alu_share_arbiter_if #(.DATA_W(DW), .OP_W(OW)) r0 ();
  alu_share_arbiter_if #(.DATA_W(DW), .OP_W(OW)) r1 ();

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW), .RST_LAST(1'b1)) dut (
    .clk(clk), .rst(rst), .port0(r0), .port1(r1),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: {zero, result}.
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a * b;
      4'd4:  r = a ^ b;
      4'd5:  r = b << a[4:0];
      4'd6:  r = a - b;
      4'd7:  r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = b >> a[4:0];
      4'd9:  r = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Stand-in combinational ALU behind the arbiter.
  always_comb {alu_zero, alu_result} = alu_ref(alu_control, alu_a, alu_b);

  function automatic logic rdy(input int n);
    return (n != 0) ? r1.req_ready : r0.req_ready;
  endfunction
  function automatic logic rvld(input int n);
    return (n != 0) ? r1.rsp_valid : r0.rsp_valid;
  endfunction
  function automatic logic [31:0] rres(input int n);
    return (n != 0) ? r1.rsp_result : r0.rsp_result;
  endfunction
  function automatic logic rzero(input int n);
    return (n != 0) ? r1.rsp_zero : r0.rsp_zero;
  endfunction

  task automatic drive_req(input int n, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n != 0) begin r1.req_valid = v; r1.req_op = op; r1.req_a = a; r1.req_b = b; end
    else        begin r0.req_valid = v; r0.req_op = op; r0.req_a = a; r0.req_b = b; end
  endtask

  task automatic set_rsp_ready(input int n, input logic v);
    if (n != 0) r1.rsp_ready = v;
    else        r0.rsp_ready = v;
  endtask

  // One full operation starting at a negedge in IDLE. pat[n] = requester n
  // valid; the loser keeps its request up. The owner withholds rsp_ready
  // for 'hold' cycles. Ends at the negedge after the response is accepted.
  task automatic run_op(input string tag, input logic [1:0] pat,
                        input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input int hold);
    int w, l;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [32:0] exp;
    w   = (pat == 2'b11) ? (last_m ? 0 : 1) : (pat[1] ? 1 : 0);
    l   = 1 - w;
    op  = (w != 0) ? op1 : op0;
    a   = (w != 0) ? a1 : a0;
    b   = (w != 0) ? b1 : b0;
    exp = alu_ref(op, a, b);
    drive_req(0, pat[0], op0, a0, b0);
    drive_req(1, pat[1], op1, a1, b1);
    set_rsp_ready(w, hold == 0);
    set_rsp_ready(l, 1'b1);
    #1;
    checks++; if (rdy(w) !== 1'b1) begin errors++; $display("FAIL %s ready%0d got %b exp 1", tag, w, rdy(w)); end
    checks++; if (rdy(l) !== 1'b0) begin errors++; $display("FAIL %s ready%0d got %b exp 0", tag, l, rdy(l)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s idle_busy got %b exp 0", tag, busy); end
    @(posedge clk); #1;
    drive_req(w, 1'b0, op, a, b);
    last_m = (w == 1);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s exec_busy got %b exp 1", tag, busy); end
    checks++;
    if ({alu_control, alu_a, alu_b} !== {op, a, b}) begin
      errors++; $display("FAIL %s alu_in got %h/%h/%h exp %h/%h/%h", tag, alu_control, alu_a, alu_b, op, a, b);
    end
    checks++; if ((rvld(0) | rvld(1)) !== 1'b0) begin errors++; $display("FAIL %s exec_rsp got %b%b exp 00", tag, rvld(1), rvld(0)); end
    @(posedge clk); @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (rvld(w) !== 1'b1 || rvld(l) !== 1'b0) begin
        errors++; $display("FAIL %s rsp_valid c%0d got %b/%b exp 1/0", tag, i, rvld(w), rvld(l));
      end
      checks++;
      if ({rzero(w), rres(w)} !== exp) begin
        errors++; $display("FAIL %s result c%0d got z=%b %h exp z=%b %h", tag, i, rzero(w), rres(w), exp[32], exp[31:0]);
      end
      checks++;
      if (rres(l) !== 32'd0 || rzero(l) !== 1'b0) begin
        errors++; $display("FAIL %s other_rsp c%0d got z=%b %h exp 0", tag, i, rzero(l), rres(l));
      end
      checks++;
      if (rdy(l) !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL %s resp_block c%0d got ready=%b busy=%b exp 0/1", tag, i, rdy(l), busy);
      end
      if (i == hold) set_rsp_ready(w, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || rvld(w) !== 1'b0) begin
      errors++; $display("FAIL %s after_accept got busy=%b vld=%b exp 0/0", tag, busy, rvld(w));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_req(0, 1'b1, 4'd2, 32'd1, 32'd1);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    set_rsp_ready(0, 1'b1);
    set_rsp_ready(1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if ({alu_control, alu_a, alu_b} !== '0) begin
      errors++; $display("FAIL reset_alu got %h/%h/%h exp 0", alu_control, alu_a, alu_b);
    end
    checks++;
    if ({r0.rsp_valid, r1.rsp_valid, r0.rsp_result, r1.rsp_result} !== '0) begin
      errors++; $display("FAIL reset_rsp got %b%b %h %h exp 0", r0.rsp_valid, r1.rsp_valid, r0.rsp_result, r1.rsp_result);
    end
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    rst = 1'b0;
    last_m = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, r0.req_ready, r1.req_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got busy=%b rdy=%b%b exp 0", busy, r1.req_ready, r0.req_ready);
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++)
      run_op("alternate", 2'b11, 4'd0, 32'hF0F0, 32'h0FF0, 4'd1, 32'hF0F0, 32'h0FF0, 0);
  endtask

  task automatic test_basic();
    run_op("add", 2'b01, 4'd2, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0);
    run_op("sub", 2'b10, 4'd0, 32'd0, 32'd0, 4'd6, 32'd9, 32'd9, 0);
    run_op("badop", 2'b01, 4'd13, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 0);
    run_op("slt", 2'b10, 4'd0, 32'd0, 32'd0, 4'd7, 32'hFFFF_FFFF, 32'd1, 0);
  endtask

  // Owner stalls the response while the other requester waits, then the
  // waiting requester must win the very next IDLE cycle.
  task automatic test_backpressure();
    run_op("stall", 2'b11, 4'd2, 32'd100, 32'd23, 4'd6, 32'd50, 32'd8, 5);
    run_op("after_stall", 2'b11, 4'd4, 32'h1234, 32'hFF00, 4'd12, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset_exec();
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(0, 1'b1, 4'd3, 32'd3, 32'd4);
    #1;
    checks++; if (r0.req_ready !== 1'b1) begin errors++; $display("FAIL rexec_ready got %b exp 1", r0.req_ready); end
    @(posedge clk); #1;
    drive_req(0, 1'b0, 4'd3, 32'd3, 32'd4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({busy, alu_control, alu_a, alu_b, r0.rsp_valid, r1.rsp_valid} !== '0) begin
      errors++; $display("FAIL rexec_clear got busy=%b alu=%h/%h/%h vld=%b%b exp 0", busy, alu_control, alu_a, alu_b, r1.rsp_valid, r0.rsp_valid);
    end
    rst = 1'b0;
    last_m = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({busy, r0.rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL rexec_dropped got busy=%b vld0=%b exp 0/0", busy, r0.rsp_valid);
    end
    run_op("rexec_tie", 2'b11, 4'd5, 32'd4, 32'd3, 4'd8, 32'd1, 32'd8, 0);
  endtask

  // Requester 0 raises and then withdraws its request while requester 1 owns the ALU.
  task automatic test_cancel();
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1, 1'b1, 4'd9, 32'd3, 32'd3);
    set_rsp_ready(1, 1'b0);
    #1;
    checks++; if (r1.req_ready !== 1'b1) begin errors++; $display("FAIL cancel_grant1 got %b exp 1", r1.req_ready); end
    @(posedge clk); #1;
    drive_req(1, 1'b0, 4'd9, 32'd3, 32'd3);
    drive_req(0, 1'b1, 4'd2, 32'd1, 32'd2);
    last_m = 1'b1;
    @(negedge clk);
    checks++; if (r0.req_ready !== 1'b0) begin errors++; $display("FAIL cancel_exec_rdy got %b exp 0", r0.req_ready); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (r1.rsp_valid !== 1'b1 || {r1.rsp_zero, r1.rsp_result} !== 33'h0_0000_0001) begin
      errors++; $display("FAIL cancel_rsp1 got v=%b z=%b %h exp 1 0 1", r1.rsp_valid, r1.rsp_zero, r1.rsp_result);
    end
    drive_req(0, 1'b0, 4'd2, 32'd1, 32'd2);
    set_rsp_ready(1, 1'b1);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({busy, r0.req_ready, r0.rsp_valid, r1.rsp_valid} !== 4'b0000) begin
        errors++; $display("FAIL cancel_idle got busy=%b rdy0=%b vld=%b%b exp 0", busy, r0.req_ready, r1.rsp_valid, r0.rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] pat;
    for (int i = 0; i < 25; i++) begin
      pat = 2'($urandom_range(1, 3));
      run_op("random", pat,
             4'($urandom_range(0, 15)), $urandom, 32'($urandom_range(0, 40)),
             4'($urandom_range(0, 15)), 32'($urandom_range(0, 40)), $urandom,
             int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_basic();
    test_backpressure();
    test_reset_exec();
    test_cancel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
